// File: rtl/chord_voice_scheduler.sv
// Chord voice scheduler: hands note events to three chord voices and paces the stream in beats.
// Optional VOICE_STEAL_EN: when every voice is busy, the least recently loaded voice is cut.
module chord_voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int ADV_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play,
    input  logic             beat,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [5:0]       note_in,
    input  logic [5:0]       duration_in,
    input  logic [ADV_W-1:0] advance_in,
    output logic [5:0]       note_to_load1,
    output logic [5:0]       note_to_load2,
    output logic [5:0]       note_to_load3,
    output logic [5:0]       duration_to_load1,
    output logic [5:0]       duration_to_load2,
    output logic [5:0]       duration_to_load3,
    output logic             load_new_note1,
    output logic             load_new_note2,
    output logic             load_new_note3,
    input  logic             done_with_note1,
    input  logic             done_with_note2,
    input  logic             done_with_note3,
`ifdef VOICE_STEAL_EN
    output logic             stolen,
`endif
    output logic             waiting
);

    typedef enum logic [1:0] {ACCEPT, DISPATCH, WAIT} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADV_W-1:0]      count;
    logic [NUM_VOICES-1:0] done;
    logic [NUM_VOICES-1:0] pending;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] sel;
    logic [NUM_VOICES-1:0] load_pulse;
    logic [5:0]            voice_note [NUM_VOICES];
    logic [5:0]            voice_dur  [NUM_VOICES];
    logic                  handshake;
    logic                  is_rest;

    assign done      = {done_with_note3, done_with_note2, done_with_note1};
    assign free      = done & ~pending;
    assign is_rest   = (note_in == 6'd0);
    assign handshake = note_valid && note_ready;

`ifdef VOICE_STEAL_EN
    localparam logic [1:0] OLDEST = 2'(NUM_VOICES - 1);

    logic [1:0] age [NUM_VOICES];
    logic [1:0] age_sel;
    logic       steal;
    logic       stolen_q;

    assign stolen = stolen_q;
`endif

    // Lowest-index free voice; with stealing, fall back to the oldest load.
    always_comb begin
        sel = '0;
`ifdef VOICE_STEAL_EN
        steal   = 1'b0;
        age_sel = '0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (free[i] && sel == '0) sel[i] = 1'b1;
        end
`ifdef VOICE_STEAL_EN
        if (free == '0) begin
            steal = 1'b1;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (age[i] == OLDEST) sel[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (sel[i]) age_sel = age[i];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ACCEPT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ACCEPT:   if (handshake) state_next = DISPATCH;
            DISPATCH: state_next = (count == '0) ? ACCEPT : WAIT;
            WAIT:     if (count == '0) state_next = ACCEPT;
            default:  state_next = ACCEPT;
        endcase
    end

    always_comb begin
        note_ready = 1'b0;
        waiting    = (state == WAIT);
        if (state == ACCEPT && play) begin
`ifdef VOICE_STEAL_EN
            note_ready = 1'b1;
`else
            note_ready = (|free) || is_rest;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            load_pulse <= '0;
            count      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_note[i] <= '0;
                voice_dur[i]  <= '0;
            end
`ifdef VOICE_STEAL_EN
            stolen_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age[i] <= 2'(NUM_VOICES - 1 - i);
            end
`endif
        end else begin
            load_pulse <= '0;
            // A load re-arms pending; a voice that has dropped done releases it.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (handshake && !is_rest && sel[i]) begin
                    pending[i]    <= 1'b1;
                    load_pulse[i] <= 1'b1;
                    voice_note[i] <= note_in;
                    voice_dur[i]  <= duration_in;
                end else if (!done[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (handshake) begin
                count <= advance_in;
            end else if (state == WAIT && beat && play && count != '0) begin
                count <= count - 1'b1;
            end
`ifdef VOICE_STEAL_EN
            stolen_q <= handshake && !is_rest && steal;
            if (handshake && !is_rest) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (sel[i])                 age[i] <= '0;
                    else if (age[i] < age_sel)  age[i] <= age[i] + 1'b1;
                end
            end
`endif
        end
    end

    assign note_to_load1     = voice_note[0];
    assign note_to_load2     = voice_note[1];
    assign note_to_load3     = voice_note[2];
    assign duration_to_load1 = voice_dur[0];
    assign duration_to_load2 = voice_dur[1];
    assign duration_to_load3 = voice_dur[2];
    assign load_new_note1    = load_pulse[0];
    assign load_new_note2    = load_pulse[1];
    assign load_new_note3    = load_pulse[2];

endmodule

// File: tb/tb_chord_voice_scheduler.sv
// Directed bench for chord_voice_scheduler; define VOICE_STEAL_EN to exercise voice stealing.
module tb_chord_voice_scheduler;

    logic       clk = 1'b0;
    logic       reset, play, beat, note_valid, note_ready;
    logic [5:0] note_in, duration_in, advance_in;
    logic [5:0] note_to_load1, note_to_load2, note_to_load3;
    logic [5:0] duration_to_load1, duration_to_load2, duration_to_load3;
    logic       load_new_note1, load_new_note2, load_new_note3;
    logic       done_with_note1, done_with_note2, done_with_note3;
    logic       waiting;
`ifdef VOICE_STEAL_EN
    logic       stolen;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    chord_voice_scheduler dut (
        .clk(clk),
        .reset(reset),
        .play(play),
        .beat(beat),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_in(note_in),
        .duration_in(duration_in),
        .advance_in(advance_in),
        .note_to_load1(note_to_load1),
        .note_to_load2(note_to_load2),
        .note_to_load3(note_to_load3),
        .duration_to_load1(duration_to_load1),
        .duration_to_load2(duration_to_load2),
        .duration_to_load3(duration_to_load3),
        .load_new_note1(load_new_note1),
        .load_new_note2(load_new_note2),
        .load_new_note3(load_new_note3),
        .done_with_note1(done_with_note1),
        .done_with_note2(done_with_note2),
        .done_with_note3(done_with_note3),
`ifdef VOICE_STEAL_EN
        .stolen(stolen),
`endif
        .waiting(waiting)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] loads();
        return {load_new_note3, load_new_note2, load_new_note1};
    endfunction

    task automatic event_in(input logic [5:0] n, input logic [5:0] d, input logic [5:0] a);
        note_valid  = 1'b1;
        note_in     = n;
        duration_in = d;
        advance_in  = a;
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; beat = 1'b0; note_valid = 1'b0;
        note_in = '0; duration_in = '0; advance_in = '0;
        done_with_note1 = 1'b1; done_with_note2 = 1'b1; done_with_note3 = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_ready", note_ready, 0);
        chk("reset_waiting", waiting, 0);
        chk("reset_loads", loads(), 0);
        chk("reset_note1", note_to_load1, 0);
        chk("reset_dur3", duration_to_load3, 0);

        // single event, voice 1
        play = 1'b1;
        event_in(12, 10, 0);
        #1;
        chk("t1_ready_T", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t1_loads", loads(), 3'b001);
        chk("t1_note1", note_to_load1, 12);
        chk("t1_dur1", duration_to_load1, 10);
        chk("t1_ready_disp", note_ready, 0);
        tick();
        chk("t1_loads_after", loads(), 0);
        chk("t1_ready_T2", note_ready, 1);
        done_with_note1 = 1'b0;
        tick();
        done_with_note1 = 1'b1;
        tick();

        // chord of three, then 24-beat wait
        event_in(20, 5, 0);
        #1;
        chk("t2_readyA", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t2_loadA", loads(), 3'b001);
        chk("t2_noteA", note_to_load1, 20);
        tick();
        done_with_note1 = 1'b0;
        event_in(21, 6, 0);
        #1;
        chk("t2_readyB", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t2_loadB", loads(), 3'b010);
        chk("t2_noteB", note_to_load2, 21);
        chk("t2_note1_held", note_to_load1, 20);
        tick();
        done_with_note2 = 1'b0;
        event_in(22, 7, 24);
        #1;
        chk("t2_readyC", note_ready, 1);
        tick();
        note_valid = 1'b0;
        beat = 1'b1;
        #1;
        chk("t2_loadC", loads(), 3'b100);
        chk("t2_noteC", note_to_load3, 22);
        chk("t2_durC", duration_to_load3, 7);
        chk("t2_wait_disp", waiting, 0);
        tick();
        beat = 1'b0;
        done_with_note3 = 1'b0;
        #1;
        chk("t2_waiting", waiting, 1);
        chk("t2_loads_idle", loads(), 0);
        for (int i = 0; i < 23; i++) begin
            beat = 1'b1; tick(); beat = 1'b0; tick(); tick();
        end
        event_in(30, 9, 0);
        #1;
        chk("t2_wait_23", waiting, 1);
        chk("t2_ready_23", note_ready, 0);
        beat = 1'b1; tick(); beat = 1'b0;
        #1;
        chk("t2_wait_zero", waiting, 1);
        tick();
        chk("t2_accept", waiting, 0);

        // fourth event with every voice busy
`ifdef VOICE_STEAL_EN
        chk("t3_ready_steal", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t3_steal_load", loads(), 3'b001);
        chk("t3_stolen", stolen, 1);
        chk("t3_steal_note", note_to_load1, 30);
        tick();
        chk("t3_stolen_off", stolen, 0);
        chk("t3_loads_off", loads(), 0);
`else
        chk("t3_ready_busy", note_ready, 0);
        tick(); tick();
        chk("t3_ready_stall", note_ready, 0);
        chk("t3_loads_stall", loads(), 0);
        done_with_note2 = 1'b1;
        #1;
        chk("t3_ready_free", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t3_load2", loads(), 3'b010);
        chk("t3_note2", note_to_load2, 30);
        tick();
        done_with_note2 = 1'b0;
        #1;
        chk("t3_loads_off", loads(), 0);
        chk("t3_ready_busy2", note_ready, 0);
`endif

        // rest with every voice busy
        event_in(0, 0, 5);
        #1;
        chk("t4_ready_rest", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t4_no_load", loads(), 0);
        tick();
        chk("t4_waiting", waiting, 1);
        for (int i = 0; i < 4; i++) begin
            beat = 1'b1; tick(); beat = 1'b0; tick();
        end
        chk("t4_wait_4", waiting, 1);
        beat = 1'b1; tick(); beat = 1'b0;
        tick();
        chk("t4_accept", waiting, 0);

        // pause during wait freezes the counter
        done_with_note3 = 1'b1;
        event_in(40, 2, 3);
        #1;
        chk("t5_ready", note_ready, 1);
        tick();
        note_valid = 1'b0;
        #1;
        chk("t5_load3", loads(), 3'b100);
        chk("t5_note3", note_to_load3, 40);
        tick();
        chk("t5_waiting", waiting, 1);
        beat = 1'b1; tick(); beat = 1'b0;
        play = 1'b0;
        for (int i = 0; i < 25; i++) begin
            beat = 1'b1; tick(); beat = 1'b0; tick(); tick(); tick();
        end
        chk("t5_paused_wait", waiting, 1);
        chk("t5_paused_ready", note_ready, 0);
        play = 1'b1;
        tick();
        chk("t5_resume_wait", waiting, 1);
        beat = 1'b1; tick(); beat = 1'b0;
        #1;
        chk("t5_after_1", waiting, 1);
        beat = 1'b1; tick(); beat = 1'b0;
        #1;
        chk("t5_after_2", waiting, 1);
        tick();
        chk("t5_accept", waiting, 0);

        // reset during dispatch
        done_with_note1 = 1'b1;
        event_in(50, 3, 0);
        #1;
        chk("t6_ready", note_ready, 1);
        tick();
        note_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_disp_load", loads(), 3'b001);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_loads", loads(), 0);
        chk("t6_waiting", waiting, 0);
        chk("t6_note1", note_to_load1, 0);
        chk("t6_note3", note_to_load3, 0);
        chk("t6_dur3", duration_to_load3, 0);
        chk("t6_accept", note_ready, 1);
`ifdef VOICE_STEAL_EN
        chk("t6_stolen", stolen, 0);
`endif
        tick();
        chk("t6_no_late_load", loads(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/chord_voice_scheduler.md
Name: chord_voice_scheduler

Overview:
- Sits between the song reader and the three-voice chord player.
- Accepts a stream of note events (note, duration, time advance) over a valid/ready handshake and assigns each event to a free voice.
- Drives that voice's note/duration/load inputs, then holds the stream for the event's time advance, counted in 1/48 s beats.
- An advance of 0 means the next event starts in the same instant, which is how chords are formed.

Parameters:
- NUM_VOICES, 3, number of voice slots; the port list is fixed for 3.
- ADV_W, 6, width of the advance field and the beat counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  high = run; low = pause (no accepts, beat counting frozen)
- beat  in  1  one-cycle 1/48 s tick
- note_valid  in  1  event presented by the song reader
- note_ready  out  1  scheduler accepts the event this cycle
- note_in  in  6  note index; 0 = rest
- duration_in  in  6  note duration in beats
- advance_in  in  6  beats to wait before accepting the next event
- note_to_load1..3  out  6 each  note for voice N
- duration_to_load1..3  out  6 each  duration for voice N
- load_new_note1..3  out  1 each  one-cycle load pulse for voice N
- done_with_note1..3  in  1 each  voice N is idle (level)
- waiting  out  1  high while in WAIT

Behaviour:
- Reset (sync, active-high): state = ACCEPT; all outputs 0; pending[1..3] = 0; counter = 0.
- Reset mid-operation: clears any WAIT and any load pulse in flight; no load pulse may appear in the cycle after reset.
- Voice N is free when done_with_noteN = 1 and pendingN = 0.
  - pendingN is set in the cycle loadN pulses.
  - pendingN is cleared on the first cycle that done_with_noteN = 0.
  - This keeps a voice from being handed two events before it has acknowledged the first.
- ACCEPT:
  - note_ready = play && (any voice free || note_in == 0).
  - Handshake in cycle T: note_valid && note_ready. Latch the event and go to DISPATCH.
  - If no voice is free, note_ready stays low and the stream stalls until a voice frees.
- DISPATCH (exactly one cycle, T+1):
  - note_ready = 0.
  - If note != 0: pick the lowest-index free voice, as evaluated at cycle T.
    - note_to_loadN and duration_to_loadN are registered at T+1 and held stable until that voice's next load.
    - load_new_noteN is high during T+1 only.
  - If note == 0 (rest): no load pulse and no voice consumed.
  - Next state: if advance == 0, go to ACCEPT, so the earliest next handshake is T+2. Otherwise load counter = advance and go to WAIT.
- WAIT:
  - Counter decrements on each cycle with beat && play.
  - When the counter reaches 0, go to ACCEPT on the following cycle.
  - A beat arriving during DISPATCH is ignored; the first decrement is on the first beat seen in WAIT.
  - The counter never wraps (63 is the maximum).
- play low:
  - note_ready = 0; the WAIT counter holds.
  - A DISPATCH already in progress still completes its load pulse.
- waiting = (state == WAIT).
- At most one load pulse per cycle, across all voices.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: when all voices are busy in ACCEPT, note_ready = play anyway.
  - The event is assigned to the voice loaded least recently, tracked with a 2-bit age order updated on every load.
  - That voice's pending flag is forced on and it receives a load pulse, cutting its old note.
  - A one-cycle output stolen (1 bit) pulses with the load.
- Undefined: stall as described above; no stolen port exists.

Test Plan:
- Reset, all done_with_note = 1, event (note 12, dur 10, adv 0) → load_new_note1 pulses at T+1, note_to_load1 = 12, duration_to_load1 = 10, note_ready back high at T+2.
- Three events, adv 0/0/24 → voices 1, 2, 3 loaded on consecutive dispatches; waiting high; next handshake only after the 24th beat in WAIT.
- Fourth event while all three voices are busy → note_ready = 0 until done_with_note2 rises; then voice 2 is loaded. With VOICE_STEAL_EN: voice 1 is loaded immediately and stolen pulses.
- Rest event (note 0, adv 5) with all voices busy → accepted, no load pulse, 5 beats of WAIT.
- Event with adv 3; drop play after 1 beat for 100 cycles with beats continuing → counter holds at 2; resume → 2 more beats, then ACCEPT.
- Assert reset in the DISPATCH cycle → no load pulse, state ACCEPT, all outputs 0 the next cycle.
